// File: rtl/wr_ptr_full_if.sv
// Write-side FIFO pointer bus: producer request, synchronized read pointer,
// and the pointer/flag outputs of the write-domain pointer block.
interface wr_ptr_full_if #(
  parameter int ptr_width = 8
);
  logic                 winc;
  logic [ptr_width:0]   rptr_sync;
  logic                 clr_ovf;
  logic                 wr_accept;
  logic [ptr_width-1:0] waddr;
  logic [ptr_width:0]   wptr;
  logic                 wfull;
  logic                 wafull;
  logic [ptr_width:0]   wcount;
  logic                 woverflow;

  // Producer / system side.
  modport master (
    output winc, rptr_sync, clr_ovf,
    input  wr_accept, waddr, wptr, wfull, wafull, wcount, woverflow
  );

  // Pointer block side.
  modport slave (
    input  winc, rptr_sync, clr_ovf,
    output wr_accept, waddr, wptr, wfull, wafull, wcount, woverflow
  );
endinterface

// File: rtl/wr_ptr_full.sv
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// Owns the binary write pointer, publishes it in Gray code, and derives
// full / almost-full / occupancy against the synchronized read pointer.
module wr_ptr_full #(
  parameter int ptr_width    = 8,
  parameter int AFULL_THRESH = (1 << ptr_width) - 4
) (
  input logic            wrclk,
  input logic            wr_rst,
  wr_ptr_full_if.slave   bus
);
  localparam int PW1 = ptr_width + 1;
  localparam logic [ptr_width:0] AFULL_T = PW1'(AFULL_THRESH);

  logic [ptr_width:0] wbin_q, wbin_d;
  logic [ptr_width:0] wptr_q, wptr_d;
  logic [ptr_width:0] wcount_q, wcount_d;
  logic               wfull_q, wfull_d;
  logic               wafull_q, wafull_d;
  logic               wovf_q, wovf_d;
  logic [ptr_width:0] rbin_s;
  logic [ptr_width:0] rptr_full_cmp;
  logic               wr_accept;
  logic               ovf_set;

  // Gray-to-binary of the synchronized read pointer: each bit is the XOR of
  // all Gray bits from the MSB down to that position.
  for (genvar gi = 0; gi <= ptr_width; gi++) begin : g_g2b
    assign rbin_s[gi] = ^bus.rptr_sync[ptr_width:gi];
  end

  // Full pattern: write pointer equals read pointer with the top two Gray bits
  // inverted (one full lap ahead). Depth-2 FIFOs only have those two bits.
  if (ptr_width == 1) begin : g_full_narrow
    assign rptr_full_cmp = ~bus.rptr_sync;
  end else begin : g_full_wide
    assign rptr_full_cmp = {~bus.rptr_sync[ptr_width:ptr_width-1],
                            bus.rptr_sync[ptr_width-2:0]};
  end

  // A write is taken only when requested, not full, and not in reset.
  assign wr_accept = bus.winc & ~wfull_q & ~wr_rst;
  assign ovf_set   = bus.winc &  wfull_q & ~wr_rst;

  // Next-state computation for pointer, flags and occupancy.
  always_comb begin
    logic [ptr_width:0] occ;
    wbin_d   = wbin_q + {{ptr_width{1'b0}}, wr_accept};
    wptr_d   = wbin_d ^ (wbin_d >> 1);
    occ      = wbin_d - rbin_s;
    wcount_d = occ;
    wfull_d  = (wptr_d == rptr_full_cmp);
    wafull_d = (occ >= AFULL_T);
    wovf_d   = wovf_q;
    if (ovf_set) begin
      wovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      wovf_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset restarts the FIFO empty.
  always_ff @(posedge wrclk) begin
    if (wr_rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wcount_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wcount_q <= wcount_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.wr_accept = wr_accept;
  assign bus.waddr     = wbin_q[ptr_width-1:0];
  assign bus.wptr      = wptr_q;
  assign bus.wfull     = wfull_q;
  assign bus.wafull    = wafull_q;
  assign bus.wcount    = wcount_q;
  assign bus.woverflow = wovf_q;
endmodule

// File: tb/tb_wr_ptr_full.sv
// Directed bench for wr_ptr_full at depth 8, almost-full threshold 6.
module tb_wr_ptr_full;
  localparam int PW = 3;

  logic wrclk;
  logic wr_rst;
  int   checks;
  int   failures;

  wr_ptr_full_if #(.ptr_width(PW)) bus ();

  wr_ptr_full #(.ptr_width(PW), .AFULL_THRESH(6)) dut (
    .wrclk  (wrclk),
    .wr_rst (wr_rst),
    .bus    (bus.slave)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  typedef struct {
    logic       rst;
    logic       winc;
    logic [3:0] rptr;
    logic       clr;
    logic       chk_addr;
    logic       e_acc;
    logic [2:0] e_addr;
    logic [3:0] e_wptr;
    logic       e_full;
    logic       e_afull;
    logic [3:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic winc, input logic [3:0] rptr,
                     input logic clr, input logic chk_addr, input logic e_acc,
                     input logic [2:0] e_addr, input logic [3:0] e_wptr,
                     input logic e_full, input logic e_afull,
                     input logic [3:0] e_cnt, input logic e_ovf);
    vec_t v;
    v.rst = rst; v.winc = winc; v.rptr = rptr; v.clr = clr;
    v.chk_addr = chk_addr; v.e_acc = e_acc; v.e_addr = e_addr;
    v.e_wptr = e_wptr; v.e_full = e_full; v.e_afull = e_afull;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // Apply one cycle: drive at negedge, check combinational outputs, clock,
  // then check registered outputs just after the edge.
  task automatic step(input int idx, input vec_t v);
    @(negedge wrclk);
    wr_rst        = v.rst;
    bus.winc      = v.winc;
    bus.rptr_sync = v.rptr;
    bus.clr_ovf   = v.clr;
    #1;
    check("wr_accept", idx, 32'(bus.wr_accept), 32'(v.e_acc));
    if (v.chk_addr) check("waddr", idx, 32'(bus.waddr), 32'(v.e_addr));
    @(posedge wrclk);
    #1;
    check("wptr",      idx, 32'(bus.wptr),      32'(v.e_wptr));
    check("wfull",     idx, 32'(bus.wfull),     32'(v.e_full));
    check("wafull",    idx, 32'(bus.wafull),    32'(v.e_afull));
    check("wcount",    idx, 32'(bus.wcount),    32'(v.e_cnt));
    check("woverflow", idx, 32'(bus.woverflow), 32'(v.e_ovf));
    $display("step %0d rst=%0b winc=%0b rptr=%b clr=%0b -> acc=%0b waddr=%0d wptr=%b full=%0b afull=%0b cnt=%0d ovf=%0b",
             idx, v.rst, v.winc, v.rptr, v.clr, v.e_acc, v.e_addr, v.e_wptr,
             v.e_full, v.e_afull, v.e_cnt, v.e_ovf);
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    wr_rst        = 1'b1;
    bus.winc      = 1'b1;
    bus.rptr_sync = 4'b0000;
    bus.clr_ovf   = 1'b0;

    //   rst winc rptr    clr ca acc addr wptr    full af cnt ovf
    // Reset held two cycles with a write request.
    add(1, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
    // Fill to 8.
    add(0, 1, 4'b0000, 0, 1, 1, 0, 4'b0001, 0, 0, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 1, 4'b0011, 0, 0, 2, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 2, 4'b0010, 0, 0, 3, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 3, 4'b0110, 0, 0, 4, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 4, 4'b0111, 0, 0, 5, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 5, 4'b0101, 0, 1, 6, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 6, 4'b0100, 0, 1, 7, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 7, 4'b1100, 1, 1, 8, 0);
    // Overflow attempts, clear, clear racing a set, clear again.
    add(0, 1, 4'b0000, 0, 1, 0, 0, 4'b1100, 1, 1, 8, 1);
    add(0, 1, 4'b0000, 0, 1, 0, 0, 4'b1100, 1, 1, 8, 1);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 4'b1100, 1, 1, 8, 0);
    add(0, 1, 4'b0000, 1, 1, 0, 0, 4'b1100, 1, 1, 8, 1);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 4'b1100, 1, 1, 8, 0);
    // Drain visibility: read pointer at binary 3.
    add(0, 0, 4'b0010, 0, 1, 0, 0, 4'b1100, 0, 0, 5, 0);
    // Read pointer to binary 7, then refill up to wbin=15 (full again).
    add(0, 0, 4'b0100, 0, 1, 0, 0, 4'b1100, 0, 0, 1, 0);
    add(0, 1, 4'b0100, 0, 1, 1, 0, 4'b1101, 0, 0, 2, 0);
    add(0, 1, 4'b0100, 0, 1, 1, 1, 4'b1111, 0, 0, 3, 0);
    add(0, 1, 4'b0100, 0, 1, 1, 2, 4'b1110, 0, 0, 4, 0);
    add(0, 1, 4'b0100, 0, 1, 1, 3, 4'b1010, 0, 0, 5, 0);
    add(0, 1, 4'b0100, 0, 1, 1, 4, 4'b1011, 0, 1, 6, 0);
    add(0, 1, 4'b0100, 0, 1, 1, 5, 4'b1001, 0, 1, 7, 0);
    add(0, 1, 4'b0100, 0, 1, 1, 6, 4'b1000, 1, 1, 8, 0);
    // Read pointer gray(10)=1111 -> occupancy 5, then wrap write 15 -> 0.
    add(0, 0, 4'b1111, 0, 1, 0, 7, 4'b1000, 0, 0, 5, 0);
    add(0, 1, 4'b1111, 0, 1, 1, 7, 4'b0000, 0, 1, 6, 0);
    add(0, 0, 4'b1111, 0, 1, 0, 0, 4'b0000, 0, 1, 6, 0);
    // Two more writes to full, then read advances to 13 (occupancy 5).
    add(0, 1, 4'b1111, 0, 1, 1, 0, 4'b0001, 0, 1, 7, 0);
    add(0, 1, 4'b1111, 0, 1, 1, 1, 4'b0011, 1, 1, 8, 0);
    add(0, 0, 4'b1011, 0, 1, 0, 2, 4'b0011, 0, 0, 5, 0);
    // Mid-operation reset with a write request, then restart from empty.
    add(1, 1, 4'b1011, 0, 1, 0, 2, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 0, 4'b0001, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(i, vecs[i]);
    end

    // Hand sequence: write coinciding with a read-pointer advance to 1;
    // both apply in one update, so occupancy stays at 1.
    v = '{rst:0, winc:1, rptr:4'b0001, clr:0, chk_addr:1, e_acc:1, e_addr:1,
          e_wptr:4'b0011, e_full:0, e_afull:0, e_cnt:1, e_ovf:0};
    step(100, v);

    // Hand sequence: fill to full with reader parked at 1, then check the
    // overflow flag stays sticky across idle cycles until cleared.
    for (int k = 0; k < 7; k++) begin
      v = '{rst:0, winc:1, rptr:4'b0001, clr:0, chk_addr:1, e_acc:1,
            e_addr:3'(k + 2), e_wptr:4'b0000, e_full:0, e_afull:0,
            e_cnt:4'(k + 2), e_ovf:0};
      // gray(k+3) for wbin k+3; full when wbin reaches 9.
      case (k)
        0: v.e_wptr = 4'b0010;
        1: v.e_wptr = 4'b0110;
        2: v.e_wptr = 4'b0111;
        3: v.e_wptr = 4'b0101;
        4: v.e_wptr = 4'b0100;
        5: v.e_wptr = 4'b1100;
        default: v.e_wptr = 4'b1101;
      endcase
      v.e_afull = (k + 2 >= 6);
      v.e_full  = (k == 6);
      step(200 + k, v);
    end
    v = '{rst:0, winc:1, rptr:4'b0001, clr:0, chk_addr:1, e_acc:0, e_addr:1,
          e_wptr:4'b1101, e_full:1, e_afull:1, e_cnt:8, e_ovf:1};
    step(300, v);
    for (int k = 0; k < 3; k++) begin
      v.winc = 1'b0;
      step(301 + k, v);
    end
    v.clr   = 1'b1;
    v.e_ovf = 1'b0;
    step(310, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
